// File: rtl/npu_pkg.sv
// Shared NPU types and constants: default widths, datapath typedefs,
// weight-buffer state encoding and accumulator saturation limits.
package npu_pkg;

  localparam int NPU_DATA_W = 8;
  localparam int NPU_ACC_W  = 24;

  typedef logic signed [NPU_DATA_W-1:0] act_t;
  typedef logic signed [NPU_ACC_W-1:0]  psum_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wstate_e;

  localparam psum_t SAT_MAX = {1'b0, {(NPU_ACC_W-1){1'b1}}};
  localparam psum_t SAT_MIN = {1'b1, {(NPU_ACC_W-1){1'b0}}};

endpackage

// File: rtl/systolic_pe_if.sv
// Per-PE bus bundle: west/north datapath inputs, south/east outputs, weight
// shift chain and status. The array driver is master, the PE is slave.
interface systolic_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);

  logic                     en;
  logic                     v_in;
  logic signed [DATA_W-1:0] act_in;
  logic signed [ACC_W-1:0]  psum_in;
  logic                     v_out;
  logic signed [DATA_W-1:0] act_out;
  logic signed [ACC_W-1:0]  psum_out;
  logic                     wload;
  logic signed [DATA_W-1:0] w_in;
  logic signed [DATA_W-1:0] w_out;
  logic                     wswap;
  logic                     w_ready;
  logic                     swap_err;
  logic                     ovf;
  logic                     ovf_clr;

  modport master (
    output en, v_in, act_in, psum_in, wload, w_in, wswap, ovf_clr,
    input  v_out, act_out, psum_out, w_out, w_ready, swap_err, ovf
  );

  modport slave (
    input  en, v_in, act_in, psum_in, wload, w_in, wswap, ovf_clr,
    output v_out, act_out, psum_out, w_out, w_ready, swap_err, ovf
  );

endinterface

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: sum = psum + a*w with signed overflow
// detection. Define SYSTOLIC_PE_SAT_EN to clamp on overflow instead of wrapping.
module pe_mac
  import npu_pkg::*;
#(
  parameter int DATA_W = NPU_DATA_W,
  parameter int ACC_W  = NPU_ACC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  psum,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int PW = 2 * DATA_W;

  // Overflow direction follows the shared operand sign: both negative
  // can only underflow, both positive can only overflow.
  function automatic logic signed [ACC_W-1:0] resolve_sum(
    input logic signed [ACC_W-1:0] raw,
    input logic                    of,
    input logic                    neg
  );
`ifdef SYSTOLIC_PE_SAT_EN
    if (of)
      return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      return raw;
`else
    logic unused;
    unused = of ^ neg;
    return raw;
`endif
  endfunction

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw;

  always_comb begin
    prod     = PW'(a) * PW'(w);
    prod_ext = ACC_W'(prod);
    raw      = psum + prod_ext;
    ovf      = (psum[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (raw[ACC_W-1] != psum[ACC_W-1]);
    sum      = resolve_sum(raw, ovf, psum[ACC_W-1]);
  end

endmodule

// File: rtl/systolic_pe.sv
// Weight-stationary systolic PE with double-buffered weight and shift-chain load.
// Optional build macro SYSTOLIC_PE_SAT_EN selects saturating accumulation.
module systolic_pe
  import npu_pkg::*;
#(
  parameter int DATA_W = NPU_DATA_W,
  parameter int ACC_W  = NPU_ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  systolic_pe_if.slave pe
);

  logic signed [DATA_W-1:0] w_act;
  logic signed [DATA_W-1:0] w_shadow;
  wstate_e                  state;

  logic signed [DATA_W-1:0] act_p1;
  logic signed [ACC_W-1:0]  psum_p1;
  logic                     vld_p1;
  logic                     ovf_p1;
  logic                     swap_err_p1;

  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_ovf;

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a    (pe.act_in),
    .w    (w_act),
    .psum (pe.psum_in),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );

  // Stage p0 -> p1: MAC result, activation forward, weight buffer FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_p1      <= '0;
      psum_p1     <= '0;
      vld_p1      <= 1'b0;
      ovf_p1      <= 1'b0;
      swap_err_p1 <= 1'b0;
      w_act       <= '0;
      w_shadow    <= '0;
      state       <= EMPTY;
    end else if (pe.en) begin
      act_p1 <= pe.act_in;
      vld_p1 <= pe.v_in;
      if (pe.v_in)
        psum_p1 <= mac_sum;

      if (pe.v_in && mac_ovf)
        ovf_p1 <= 1'b1;
      else if (pe.ovf_clr)
        ovf_p1 <= 1'b0;

      swap_err_p1 <= pe.wswap && (state == EMPTY);

      // Swap reads the pre-edge shadow, so a simultaneous load is safe.
      if (pe.wload)
        w_shadow <= pe.w_in;
      if (pe.wswap && (state == FULL))
        w_act <= w_shadow;

      case (state)
        EMPTY:   if (pe.wload) state <= FULL;
        FULL:    if (pe.wswap && !pe.wload) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end else begin
      swap_err_p1 <= 1'b0;
    end
  end

  assign pe.act_out  = act_p1;
  assign pe.psum_out = psum_p1;
  assign pe.v_out    = vld_p1;
  assign pe.ovf      = ovf_p1;
  assign pe.swap_err = swap_err_p1;
  assign pe.w_out    = w_shadow;
  assign pe.w_ready  = (state == FULL);

endmodule
